// File: rtl/udp_csum_accum_if.sv
// rtl/udp_csum_accum_if.sv - word stream in, folded checksum result out
interface udp_csum_accum_if;
    logic [15:0] i_word;
    logic        i_valid;
    logic        i_last;
    logic        i_odd;
    logic        o_ready;
    logic [15:0] o_sum;
    logic        o_done;
    logic        o_ok;
    logic        o_overflow;

    // Upstream source side: drives words, observes ready and results.
    modport master (
        output i_word, i_valid, i_last, i_odd,
        input  o_ready, o_sum, o_done, o_ok, o_overflow
    );

    // Accumulator side.
    modport slave (
        input  i_word, i_valid, i_last, i_odd,
        output o_ready, o_sum, o_done, o_ok, o_overflow
    );
endinterface

// File: rtl/udp_csum_accum.sv
// rtl/udp_csum_accum.sv - streaming ones-complement UDP checksum accumulator
module udp_csum_accum #(
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    udp_csum_accum_if.slave  s
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_FOLD1,
        S_FOLD2,
        S_DONE
    } state_t;

    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] acc;
    logic [15:0] cnt;
    logic        ovf_flag;
    logic [15:0] sum_q;
    logic        ok_q;
    logic        ovf_q;

    logic        taking;
    logic        accept;
    logic [15:0] contrib;
    logic [15:0] cnt_inc;
    logic        hit_max;
    logic [31:0] fold;

    // Ready is a pure function of state, so acceptance is derived from state
    // directly rather than by reading the output back.
    assign taking  = (state == S_IDLE) || (state == S_ACCUM);
    assign accept  = s.i_valid && taking;

    // A trailing single byte sits in the high half; the pad byte counts as zero.
    assign contrib = (s.i_last && s.i_odd) ? {s.i_word[15:8], 8'h00} : s.i_word;

    // Hitting the word limit only counts as overflow when the datagram has not
    // ended on that same word.
    assign cnt_inc = cnt + 16'd1;
    assign hit_max = (cnt_inc == MAX_CNT) && !s.i_last;

    // End-around carry: add the upper half back into the lower half.
    assign fold    = {16'h0000, acc[15:0]} + {16'h0000, acc[31:16]};

    assign s.o_sum      = sum_q;
    assign s.o_ok       = ok_q;
    assign s.o_overflow = ovf_q;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus ready/done decode.
    always_comb begin
        state_nxt = state;
        s.o_ready = 1'b0;
        s.o_done  = 1'b0;
        case (state)
            S_IDLE, S_ACCUM: begin
                s.o_ready = 1'b1;
                if (s.i_valid) begin
                    if (s.i_last || hit_max) begin
                        state_nxt = S_FOLD1;
                    end else begin
                        state_nxt = S_ACCUM;
                    end
                end
            end
            S_FOLD1: state_nxt = S_FOLD2;
            S_FOLD2: state_nxt = S_DONE;
            S_DONE: begin
                s.o_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Accumulate, fold twice, then capture results so they are valid during DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc      <= 32'h0000_0000;
            cnt      <= 16'h0000;
            ovf_flag <= 1'b0;
            sum_q    <= 16'h0000;
            ok_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        acc <= acc + {16'h0000, contrib};
                        cnt <= cnt_inc;
                        if (hit_max) begin
                            ovf_flag <= 1'b1;
                        end
                    end
                end
                S_FOLD1: begin
                    acc <= fold;
                end
                S_FOLD2: begin
                    acc   <= fold;
                    sum_q <= fold[15:0];
                    ok_q  <= (fold[15:0] == 16'hFFFF) && !ovf_flag;
                    ovf_q <= ovf_flag;
                end
                S_DONE: begin
                    acc      <= 32'h0000_0000;
                    cnt      <= 16'h0000;
                    ovf_flag <= 1'b0;
                end
                default: begin
                    acc      <= 32'h0000_0000;
                    cnt      <= 16'h0000;
                    ovf_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_csum_accum.sv
// tb/tb_udp_csum_accum.sv - directed checks of udp_csum_accum
module tb_udp_csum_accum;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad = 0;

    udp_csum_accum_if ifa ();
    udp_csum_accum_if ifb ();

    udp_csum_accum dut_a (
        .i_clk (clk),
        .i_rst (rst_a),
        .s     (ifa.slave)
    );

    udp_csum_accum #(.MAX_WORDS(4)) dut_b (
        .i_clk (clk),
        .i_rst (rst_b),
        .s     (ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input bit b, input logic v, input logic [15:0] w, input logic l, input logic o);
        if (b) begin
            ifb.i_valid = v; ifb.i_word = w; ifb.i_last = l; ifb.i_odd = o;
        end else begin
            ifa.i_valid = v; ifa.i_word = w; ifa.i_last = l; ifa.i_odd = o;
        end
    endtask

    function automatic logic rdy(input bit b);
        return b ? ifb.o_ready : ifa.o_ready;
    endfunction

    function automatic logic dn(input bit b);
        return b ? ifb.o_done : ifa.o_done;
    endfunction

    function automatic logic [15:0] sm(input bit b);
        return b ? ifb.o_sum : ifa.o_sum;
    endfunction

    function automatic logic okv(input bit b);
        return b ? ifb.o_ok : ifa.o_ok;
    endfunction

    function automatic logic ov(input bit b);
        return b ? ifb.o_overflow : ifa.o_overflow;
    endfunction

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic put(input bit b, input logic [15:0] w, input logic l, input logic o);
        int k = 0;
        drv(b, 1'b1, w, l, o);
        while (!rdy(b) && k < 16) begin
            @(negedge clk);
            k++;
        end
        if (!rdy(b)) begin
            total++;
            bad++;
            $error("FAIL put_timeout: ready got 0 want 1");
        end
        @(negedge clk);
        drv(b, 1'b0, 16'hDEAD, 1'b1, 1'b1);
    endtask

    // Called at the negedge of cycle N+1; done must appear at N+3 only.
    task automatic finish(input bit b, input string tag, input logic [15:0] esum,
                          input logic eok, input logic eovf);
        check({tag, ".done_n1"}, 32'(dn(b)), 32'd0);
        check({tag, ".rdy_n1"}, 32'(rdy(b)), 32'd0);
        @(negedge clk);
        check({tag, ".done_n2"}, 32'(dn(b)), 32'd0);
        @(negedge clk);
        check({tag, ".done_n3"}, 32'(dn(b)), 32'd1);
        check({tag, ".sum"}, 32'(sm(b)), 32'(esum));
        check({tag, ".ok"}, 32'(okv(b)), 32'(eok));
        check({tag, ".ovf"}, 32'(ov(b)), 32'(eovf));
        @(negedge clk);
        check({tag, ".done_n4"}, 32'(dn(b)), 32'd0);
        check({tag, ".rdy_n4"}, 32'(rdy(b)), 32'd1);
        check({tag, ".sum_hold"}, 32'(sm(b)), 32'(esum));
    endtask

    initial begin
        logic [15:0] stream [4];
        stream[0] = 16'h0001;
        stream[1] = 16'hF203;
        stream[2] = 16'hF4F5;
        stream[3] = 16'hF6F7;

        drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(ifa.o_ready), 32'd1);
        check("rst.sum", 32'(ifa.o_sum), 32'd0);
        check("rst.done", 32'(ifa.o_done), 32'd0);
        check("rst.ok", 32'(ifa.o_ok), 32'd0);
        check("rst.ovf", 32'(ifa.o_overflow), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // Multi-word sum.
        put(1'b0, 16'h0001, 1'b0, 1'b0);
        put(1'b0, 16'hF203, 1'b0, 1'b0);
        put(1'b0, 16'hF4F5, 1'b0, 1'b0);
        put(1'b0, 16'hF6F7, 1'b1, 1'b0);
        finish(1'b0, "multi", 16'hDDF2, 1'b0, 1'b0);

        // Valid checksum.
        put(1'b0, 16'h0001, 1'b0, 1'b0);
        put(1'b0, 16'hF203, 1'b0, 1'b0);
        put(1'b0, 16'hF4F5, 1'b0, 1'b0);
        put(1'b0, 16'hF6F7, 1'b0, 1'b0);
        put(1'b0, 16'h220D, 1'b1, 1'b0);
        finish(1'b0, "valid", 16'hFFFF, 1'b1, 1'b0);

        // End-around carry.
        put(1'b0, 16'hFFFF, 1'b0, 1'b0);
        put(1'b0, 16'h0001, 1'b1, 1'b0);
        finish(1'b0, "carry", 16'h0001, 1'b0, 1'b0);

        // Odd trailing byte.
        put(1'b0, 16'h1234, 1'b0, 1'b0);
        put(1'b0, 16'h56FF, 1'b1, 1'b1);
        finish(1'b0, "odd", 16'h6834, 1'b0, 1'b0);

        // Odd flag on a non-final word is ignored.
        put(1'b0, 16'h1234, 1'b0, 1'b1);
        put(1'b0, 16'h00FF, 1'b1, 1'b0);
        finish(1'b0, "odd_nolast", 16'h1333, 1'b0, 1'b0);

        // Random valid gaps give the same result.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            put(1'b0, stream[i], (i == 3), 1'b0);
        end
        finish(1'b0, "stall", 16'hDDF2, 1'b0, 1'b0);

        // Word held during fold is taken at N+4 as a new datagram.
        for (int i = 0; i < 4; i++) begin
            put(1'b0, stream[i], (i == 3), 1'b0);
        end
        drv(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        check("held.rdy_n1", 32'(ifa.o_ready), 32'd0);
        @(negedge clk);
        check("held.rdy_n2", 32'(ifa.o_ready), 32'd0);
        @(negedge clk);
        check("held.rdy_n3", 32'(ifa.o_ready), 32'd0);
        check("held.done_n3", 32'(ifa.o_done), 32'd1);
        check("held.sum1", 32'(ifa.o_sum), 32'h0000DDF2);
        @(negedge clk);
        check("held.rdy_n4", 32'(ifa.o_ready), 32'd1);
        @(negedge clk);
        drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        finish(1'b0, "held2", 16'hFFFF, 1'b1, 1'b0);

        // Overflow at MAX_WORDS=4 with no last.
        put(1'b1, 16'h0001, 1'b0, 1'b0);
        put(1'b1, 16'h0002, 1'b0, 1'b0);
        put(1'b1, 16'h0003, 1'b0, 1'b0);
        put(1'b1, 16'h0004, 1'b0, 1'b0);
        finish(1'b1, "ovf", 16'h000A, 1'b0, 1'b1);

        // Exactly MAX_WORDS words ending with last is not overflow.
        put(1'b1, 16'h0001, 1'b0, 1'b0);
        put(1'b1, 16'h0002, 1'b0, 1'b0);
        put(1'b1, 16'h0003, 1'b0, 1'b0);
        put(1'b1, 16'h0004, 1'b1, 1'b0);
        finish(1'b1, "atmax", 16'h000A, 1'b0, 1'b0);

        // Overflow flag cleared for the next datagram.
        put(1'b1, 16'hFFFF, 1'b1, 1'b0);
        finish(1'b1, "after_ovf", 16'hFFFF, 1'b1, 1'b0);

        // Reset mid-datagram, with a word offered on the reset edge.
        put(1'b0, 16'h1111, 1'b0, 1'b0);
        put(1'b0, 16'h2222, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("midrst.sum", 32'(ifa.o_sum), 32'd0);
        check("midrst.ready", 32'(ifa.o_ready), 32'd1);
        check("midrst.ok", 32'(ifa.o_ok), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("midrst.nodone", 32'(ifa.o_done), 32'd0);
            @(negedge clk);
        end
        put(1'b0, 16'hFFFF, 1'b1, 1'b0);
        finish(1'b0, "postrst", 16'hFFFF, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_csum_accum.md
# udp_csum_accum

Streaming ones-complement accumulator for UDP checksum verification. Accepts a datagram (pseudo-header, UDP header, payload) as a stream of 16-bit words, forms the 32-bit running sum, folds carries end-around into a 16-bit result, and flags whether the received checksum is valid. Sits directly upstream of the checksum verifier: `o_done` drives the verifier's `i_start`, and `o_sum` drives its `i_checksum_buffer`.

## Interface
- `MAX_WORDS`, default 1024: maximum accepted words per datagram. Legal range 1..65535.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous reset, active-high.
- `i_word`  in  16  data word; first byte on the wire is in `[15:8]`.
- `i_valid`  in  1  `i_word` is valid this cycle.
- `i_last`  in  1  qualifies `i_valid`; this is the final word of the datagram.
- `i_odd`  in  1  qualifies `i_last`; the final word carries one byte only, and `[7:0]` is treated as 0.
- `o_ready`  out  1  block accepts a word this cycle.
- `o_sum`  out  16  folded ones-complement sum; held until the next `o_done`.
- `o_done`  out  1  one-cycle pulse; `o_sum`, `o_ok` and `o_overflow` are valid.
- `o_ok`  out  1  `o_sum == 16'hFFFF` and no overflow.
- `o_overflow`  out  1  datagram exceeded `MAX_WORDS`.

## Operation
- **Transfer rule:** a word is accepted when `i_valid && o_ready`. `i_last` and `i_odd` are ignored unless the word is accepted.
- **Odd mask:** if `i_last && i_odd`, the contribution is `{i_word[15:8], 8'h00}`. `i_odd` without `i_last` is ignored.
- **Accumulator:** `acc[31:0]`, zero-extended add of each accepted word. Cannot overflow for 65535 words.
- **Word counter:** `cnt[15:0]`, counts accepted words.
- **States:**
  - IDLE: `acc=0`, `cnt=0`, `o_ready=1`. An accepted word goes to ACCUM, or to FOLD1 if `i_last`.
  - ACCUM: `o_ready=1`. An accepted word with `i_last` goes to FOLD1. An accepted word that makes `cnt == MAX_WORDS` without `i_last` sets the overflow flag and goes to FOLD1. Further input stays stalled because `o_ready` is low.
  - FOLD1: `acc <= acc[15:0] + acc[31:16]`, `o_ready=0`, then go to FOLD2.
  - FOLD2: `acc <= acc[15:0] + acc[31:16]`, `o_ready=0`, then go to DONE. After FOLD2, `acc[31:16]` is zero.
  - DONE: `o_done=1`, `o_ready=0`. Register `o_sum=acc[15:0]`, `o_overflow=flag`, `o_ok=(acc[15:0]==16'hFFFF)&&!flag`. Then go to IDLE and clear `acc`, `cnt` and the flag.
- **No-checksum case:** a transmitted checksum of `0x0000` ("no checksum") is not special-cased. The block reports the arithmetic result only.
- **Reset mid-datagram:** the partial datagram is discarded. There is no `o_done` for it, and the next accepted word starts a new datagram.
- **Input held during FOLD1/FOLD2/DONE:** `o_ready` is low, so nothing is accepted. Upstream must hold its word until ready returns.

## Timing
- **Reset values:** `o_ready=1` (the block is in IDLE), `o_sum=16'h0000`, `o_done=0`, `o_ok=0`, `o_overflow=0`.
- **Throughput:** one word per cycle in IDLE and ACCUM.
- **Latency:** last word accepted at cycle N. FOLD1 at N+1, FOLD2 at N+2, `o_done` high at N+3 with valid outputs.
- **Back-to-back datagrams:** `o_ready` returns at N+4. The next datagram's first word can be accepted at N+4, so the dead time between datagrams is 3 cycles.
- **Output hold:** `o_sum`, `o_ok` and `o_overflow` hold their values after the `o_done` pulse until the next `o_done`.
- **Reset priority:** `i_rst` overrides everything on the same edge, including an accepted word or a DONE cycle.

## Test plan
- **Multi-word sum:** words `0x0001`, `0xF203`, `0xF4F5`, `0xF6F7` (last). Required: `o_sum=0xDDF2`, `o_ok=0`, and `o_done` exactly 3 cycles after the last word is accepted.
- **Valid checksum:** same stream plus `0x220D` as the last word. Required: `o_sum=0xFFFF`, `o_ok=1`.
- **Carry fold and odd byte:**
  - `0xFFFF`, `0x0001` (last): required `o_sum=0x0001`.
  - `0x1234`, `0x56FF` (last, `i_odd`): required `o_sum=0x6834`.
- **Stalls:** random `i_valid` gaps during the first stream. Required: result identical to the gap-free run.
  - While `o_ready=0`, a held word is not accepted. It is accepted at N+4 as the first word of the next datagram.
- **Overflow:** with `MAX_WORDS=4`, drive 4 words with no `i_last`. Required: `o_overflow=1`, `o_ok=0`, `o_done` pulses.
- **Reset mid-datagram:** `i_rst` after 2 of 4 words. Required: no `o_done`, `o_sum=0`.
  - Then drive `0xFFFF` (last). Required: `o_sum=0xFFFF`, `o_ok=1`.
